// File: rtl/npc_ctrl.sv
// Multi-cycle sequencing controller for the NPC RV32 core: owns the PC, fetches over a
// req/valid handshake, and steps DECODE/EXEC/MEM/WB with registered control outputs.
module npc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    input  logic [6:0]  op,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] jal_target,
    input  logic [31:0] jalr_target,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] instret,
    output logic        halted,
    output logic [1:0]  trap
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam logic [1:0] TRAP_EBREAK  = 2'd1;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd2;
    localparam logic [1:0] TRAP_MISALGN = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] instret_q;
    logic [31:0] npc_q;
    logic        misalign_q;
    logic        imem_req_q;
    logic        dmem_req_q;
    logic        dmem_we_q;
    logic        rf_we_q;
    logic        halted_q;
    logic [1:0]  trap_q;

    logic [31:0] pc_plus4;
    logic [31:0] next_pc_d;
    logic        op_legal;
    logic        op_is_mem;
    logic        op_writes_rd;

    always_comb begin
        pc_plus4  = pc_q + 32'd4;
        next_pc_d = pc_plus4;
        case (op)
            OP_JAL:    next_pc_d = jal_target;
            OP_JALR:   next_pc_d = {jalr_target[31:1], 1'b0};
            OP_BRANCH: next_pc_d = br_taken ? br_target : pc_plus4;
            default:   next_pc_d = pc_plus4;
        endcase
    end

    always_comb begin
        op_legal = 1'b0;
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
            OP_LOAD, OP_STORE, OP_OPIMM, OP_OP: op_legal = 1'b1;
            default:                            op_legal = 1'b0;
        endcase
    end

    assign op_is_mem    = (op == OP_LOAD) || (op == OP_STORE);
    assign op_writes_rd = (op != OP_BRANCH) && (op != OP_STORE);

    // Next PC and the write strobe are resolved on the edge into WB so both leave flops;
    // the PC update and the register-file write then land together on the WB exit edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instret_q  <= 32'd0;
            npc_q      <= RESET_PC;
            misalign_q <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            rf_we_q    <= 1'b0;
            halted_q   <= 1'b0;
            trap_q     <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q    <= S_FETCH;
                    imem_req_q <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr_q    <= imem_rdata;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (op == OP_SYSTEM) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        trap_q   <= TRAP_EBREAK;
                    end else if (!op_legal) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        trap_q   <= TRAP_ILLEGAL;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (op_is_mem) begin
                        state_q    <= S_MEM;
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= (op == OP_STORE);
                    end else begin
                        state_q    <= S_WB;
                        npc_q      <= next_pc_d;
                        misalign_q <= next_pc_d[1];
                        rf_we_q    <= op_writes_rd && !next_pc_d[1];
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        state_q    <= S_WB;
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        npc_q      <= next_pc_d;
                        misalign_q <= next_pc_d[1];
                        rf_we_q    <= op_writes_rd && !next_pc_d[1];
                    end
                end
                S_WB: begin
                    rf_we_q <= 1'b0;
                    if (misalign_q) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        trap_q   <= TRAP_MISALGN;
                    end else begin
                        pc_q       <= npc_q;
                        instret_q  <= instret_q + 32'd1;
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q  <= S_HALT;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign instr     = instr_q;
    assign dmem_req  = dmem_req_q;
    assign dmem_we   = dmem_we_q;
    assign rf_we     = rf_we_q;
    assign pc        = pc_q;
    assign instret   = instret_q;
    assign halted    = halted_q;
    assign trap      = trap_q;

endmodule

// File: tb/tb_npc_ctrl.sv
// Scoreboard bench for npc_ctrl: each expected fetch request carries the address, instret,
// write-strobe count, data-access profile and spacing from the previous request.
module tb_npc_ctrl;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [6:0]  op;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] jal_target;
    logic [31:0] jalr_target;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        rf_we;
    logic [31:0] pc;
    logic [31:0] instret;
    logic        halted;
    logic [1:0]  trap;

    npc_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_rdata (imem_rdata),
        .instr      (instr),
        .op         (op),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jal_target (jal_target),
        .jalr_target(jalr_target),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ack   (dmem_ack),
        .rf_we      (rf_we),
        .pc         (pc),
        .instret    (instret),
        .halted     (halted),
        .trap       (trap)
    );

    // Bench-side stand-in for the decode block.
    assign op = instr[6:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instret;
        int          rfwe;
        int          dmem;
        bit          we;
        int          spacing;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic [31:0] prog_word = 32'h0000_0013;
    int          imem_lat  = 1;
    int          ack_lat   = 1;
    int          rfwe_total = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory responders: valid/ack rise once the request has been up for the programmed latency.
    initial begin
        int icnt;
        int dcnt;
        icnt = 0;
        dcnt = 0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        dmem_ack   = 1'b0;
        forever begin
            @(negedge clk);
            imem_rdata = prog_word;
            if (rst_n && imem_req) begin
                icnt++;
                imem_valid = (icnt >= imem_lat);
            end else begin
                icnt = 0;
                imem_valid = 1'b0;
            end
            if (rst_n && dmem_req) begin
                dcnt++;
                dmem_ack = (dcnt >= ack_lat);
            end else begin
                dcnt = 0;
                dmem_ack = 1'b0;
            end
        end
    end

    initial begin
        logic prev_req;
        int   rfwe_cnt;
        int   dmem_cnt;
        bit   we_seen;
        int   last_req_cyc;
        int   last_rfwe_cyc;
        exp_t e;
        prev_req = 1'b0;
        rfwe_cnt = 0;
        dmem_cnt = 0;
        we_seen = 1'b0;
        last_req_cyc = 0;
        last_rfwe_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                rfwe_cnt = 0;
                dmem_cnt = 0;
                we_seen = 1'b0;
                rfwe_total = 0;
            end else begin
                if (rf_we) begin
                    rfwe_cnt++;
                    rfwe_total++;
                    last_rfwe_cyc = cyc;
                end
                if (dmem_req) begin
                    dmem_cnt++;
                    if (dmem_we) we_seen = 1'b1;
                end
                if (imem_req && !prev_req) begin
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk("fetch_addr", imem_addr, e.addr);
                        chk("instret", instret, e.instret);
                        chk("rfwe_count", rfwe_cnt, e.rfwe);
                        chk("dmem_cycles", dmem_cnt, e.dmem);
                        chk("dmem_we", {31'd0, we_seen}, {31'd0, e.we});
                        if (e.spacing != 0) chk("req_spacing", cyc - last_req_cyc, e.spacing);
                        if (e.rfwe != 0) chk("rfwe_before_req", cyc - last_rfwe_cyc, 1);
                    end
                    last_req_cyc = cyc;
                    rfwe_cnt = 0;
                    dmem_cnt = 0;
                    we_seen = 1'b0;
                end
                prev_req = imem_req;
            end
        end
    end

    task automatic push_exp(input logic [31:0] addr, input logic [31:0] ir, input int rfwe,
                            input int dmem, input bit we, input int spacing);
        exp_t e;
        e.addr = addr;
        e.instret = ir;
        e.rfwe = rfwe;
        e.dmem = dmem;
        e.we = we;
        e.spacing = spacing;
        exp_q.push_back(e);
    endtask

    task automatic hold_reset();
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (!halted && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(tag, {31'd0, halted}, 32'd1);
    endtask

    task automatic check_quiet_after_halt(input string tag);
        int hi;
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (imem_req || dmem_req || rf_we) hi++;
        end
        chk(tag, hi, 0);
    endtask

    task automatic run_single(input string tag, input logic [31:0] word, input logic [31:0] next_addr,
                              input int rfwe, input int dmem, input bit we, input int spacing);
        hold_reset();
        prog_word = word;
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        push_exp(next_addr, 32'd1, rfwe, dmem, we, spacing);
        release_reset();
        wait_drain(tag, 100);
    endtask

    initial begin
        rst_n = 1'b0;
        br_taken = 1'b0;
        br_target = 32'h0;
        jal_target = 32'h0;
        jalr_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, RESET_PC);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_instret", instret, 32'd0);
        chk("rst_status", {29'd0, halted, trap}, 32'd0);
        chk("rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);

        // addi stream: three back-to-back fetches, then a slow-fetch variant.
        hold_reset();
        prog_word = 32'h0010_0093;
        imem_lat = 1;
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        push_exp(RESET_PC + 32'd4, 32'd1, 1, 0, 1'b0, 4);
        push_exp(RESET_PC + 32'd8, 32'd2, 1, 0, 1'b0, 4);
        release_reset();
        wait_drain("addi_stream", 100);

        hold_reset();
        imem_lat = 3;
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        push_exp(RESET_PC + 32'd4, 32'd1, 1, 0, 1'b0, 6);
        release_reset();
        wait_drain("addi_slow_fetch", 100);
        imem_lat = 1;

        ack_lat = 3;
        run_single("lw_ack3", 32'h0000_2083, RESET_PC + 32'd4, 1, 3, 1'b0, 7);
        ack_lat = 1;
        run_single("sw_zero_wait", 32'h0010_2023, RESET_PC + 32'd4, 0, 1, 1'b1, 5);

        br_taken = 1'b1;
        br_target = 32'h8000_0100;
        run_single("beq_taken", 32'h0000_0063, 32'h8000_0100, 0, 0, 1'b0, 4);
        br_taken = 1'b0;
        run_single("beq_not_taken", 32'h0000_0063, RESET_PC + 32'd4, 0, 0, 1'b0, 4);

        jal_target = 32'h8000_0200;
        run_single("jal", 32'h0000_00EF, 32'h8000_0200, 1, 0, 1'b0, 4);
        jalr_target = 32'h8000_0011;
        run_single("jalr_clear_lsb", 32'h0000_80E7, 32'h8000_0010, 1, 0, 1'b0, 4);

        // jalr to a half-word aligned target must trap without retiring.
        hold_reset();
        prog_word = 32'h0000_80E7;
        jalr_target = 32'h8000_0012;
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        release_reset();
        wait_halt("jalr_misalign_halt", 50);
        chk("jalr_misalign_trap", {30'd0, trap}, 32'd3);
        chk("jalr_misalign_pc", pc, RESET_PC);
        chk("jalr_misalign_instret", instret, 32'd0);
        chk("jalr_misalign_rfwe", rfwe_total, 0);
        check_quiet_after_halt("jalr_misalign_quiet");

        hold_reset();
        prog_word = 32'h0010_0073;
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        release_reset();
        wait_halt("ebreak_halt", 50);
        chk("ebreak_trap", {30'd0, trap}, 32'd1);
        check_quiet_after_halt("ebreak_quiet");
        chk("ebreak_instret", instret, 32'd0);

        hold_reset();
        prog_word = 32'h0000_007F;
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        release_reset();
        wait_halt("illegal_halt", 50);
        chk("illegal_trap", {30'd0, trap}, 32'd2);
        check_quiet_after_halt("illegal_quiet");

        // Reset pulled mid-MEM must drop dmem_req without a clock edge.
        hold_reset();
        prog_word = 32'h0000_2083;
        ack_lat = 1000;
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        release_reset();
        begin
            int n;
            n = 0;
            while (!dmem_req && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("mid_mem_req_seen", {31'd0, dmem_req}, 32'd1);
        end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_dmem_req_drop", {31'd0, dmem_req}, 32'd0);
        chk("async_pc", pc, RESET_PC);
        chk("async_instr", instr, 32'h0000_0013);
        chk("async_status", {29'd0, halted, trap}, 32'd0);
        chk("async_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
        exp_q.delete();
        ack_lat = 1;
        repeat (2) @(posedge clk);
        push_exp(RESET_PC, 32'd0, 0, 0, 1'b0, 0);
        push_exp(RESET_PC + 32'd4, 32'd1, 1, 1, 1'b0, 5);
        release_reset();
        wait_drain("restart_after_async", 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/npc_ctrl.md
# npc_ctrl

Multi-cycle sequencing controller for the NPC single-issue RV32 core. It owns the PC and fetches instructions over a request/valid handshake. It holds the fetched word stable for the combinational `decode` block, steps the datapath through DECODE/EXEC/MEM/WB, and selects the next PC. It also issues the data-memory handshake, the register-file write strobe, the retired-instruction count and a halt/trap status.

## Interface
Parameters:
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  32  fetch address (equals pc).
- imem_valid  in  1  fetch data valid, sampled only in FETCH.
- imem_rdata  in  32  fetched instruction word.
- instr  out  32  latched instruction, feeds `decode.instr`.
- op  in  7  opcode returned by `decode`.
- br_taken  in  1  branch condition from the ALU compare.
- br_target  in  32  pc + sign-extended B-immediate.
- jal_target  in  32  pc + sign-extended J-immediate.
- jalr_target  in  32  rs1 + sign-extended I-immediate.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req is high.
- dmem_ack  in  1  data access done, sampled only in MEM.
- rf_we  out  1  register-file write strobe, one cycle.
- pc  out  32  current PC.
- instret  out  32  retired instruction count.
- halted  out  1  sticky; core stopped.
- trap  out  2  sticky cause: 0 none, 1 ebreak, 2 illegal opcode, 3 misaligned target.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Encoding is free.
- IDLE: entered on reset and held for one cycle, then go to FETCH.
- FETCH: drive imem_req=1 with imem_addr=pc. On imem_valid=1, latch instr=imem_rdata and go to DECODE. Otherwise stay in FETCH with no timeout.
- DECODE: one cycle; classify op.
  - 1110011 → HALT with trap=1.
  - An opcode outside {0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0010011, 0110011} → HALT with trap=2.
  - Anything else → EXEC.
- EXEC: one cycle for operand and target settling. Load (0000011) or store (0100011) → MEM; anything else → WB.
- MEM: drive dmem_req=1 and dmem_we=(op==0100011). Hold until dmem_ack=1, then go to WB.
- WB, one cycle:
  - rf_we=1 for every class except branch (1100011) and store (0100011).
  - Next PC: jal → jal_target; jalr → {jalr_target[31:1],1'b0}; branch → br_taken ? br_target : pc+4; all others → pc+4.
  - If next PC bit 1 is set: pc is left unchanged, rf_we is forced to 0, instret is not incremented, and the block goes to HALT with trap=3.
  - Otherwise: update pc, increment instret (wraps from 32'hFFFF_FFFF to 0), go to FETCH.
- HALT: absorbing state. All request and strobe outputs are 0 and halted=1. Only reset exits.
- pc+4 is 32-bit modulo; 32'hFFFF_FFFC wraps to 0.

## Timing
- Reset values: pc=RESET_PC, instr=32'h0000_0013, instret=0, halted=0, trap=0. imem_req, dmem_req, dmem_we and rf_we are all 0.
- Assertion of rst_n aborts any transaction immediately; imem_req and dmem_req fall without waiting for a clock edge.
- imem_addr is stable for the whole time imem_req is high. dmem_we is stable for the whole time dmem_req is high.
- imem_valid and dmem_ack are ignored in every other state.
- instr changes only on the FETCH→DECODE edge.
- Best-case latency, request to next request:
  - ALU/jump/branch: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles.
  - Each extra cycle of imem_valid or dmem_ack latency adds one cycle.
- rf_we and the pc update share one edge: the WB→FETCH edge.
- An ack arriving in the same cycle as the req (zero-wait) is legal and is taken that cycle.

## Test plan
- Reset release, imem_valid tied 1, instr 32'h00100093 (addi) → first imem_addr is 32'h8000_0000. rf_we pulses 4 cycles after the first request. The next imem_addr is 32'h8000_0004 and instret=1.
- lw with dmem_ack delayed 3 cycles → dmem_req high for 3 cycles with dmem_we=0. rf_we pulses one cycle after the ack. Request-to-request spacing is 7 cycles.
- beq with br_taken=1 and br_target=32'h8000_0100 → pc becomes 32'h8000_0100 and rf_we stays 0. Repeat with br_taken=0 → pc becomes 32'h8000_0004.
- jalr with jalr_target=32'h8000_0011 → pc becomes 32'h8000_0010. With jalr_target=32'h8000_0012 → halted=1, trap=3, pc unchanged, instret unchanged.
- Fetch 32'h00100073 (ebreak) → halted=1 and trap=1 after DECODE. Fetch 32'h0000007F → trap=2. In both cases imem_req stays 0 afterwards.
- rst_n pulled low mid-MEM while dmem_req=1 → dmem_req drops asynchronously and all outputs take their reset values. After release, fetch restarts at RESET_PC.
